// File: rtl/paralelo_serial_pkg.sv
//==============================================================================
// Module      : paralelo_serial_pkg
// Description : Shared constants and state type for the parallel-to-serial
//               comma-framed transmitter.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

package paralelo_serial_pkg;

   // Comma byte: sent during sync and whenever no payload byte is waiting
   localparam logic [7:0] COMMA = 8'hBC;

   // Bit position counter width (8 bits per byte)
   localparam int BIT_CNT_W = 3;

   // Bit counter value that marks a byte boundary
   localparam logic [BIT_CNT_W-1:0] c_bit_last = 3'd7;

   // Transmitter phases
   typedef enum logic [0:0] {
      SYNC = 1'b0,
      RUN  = 1'b1
   } state_t;

endpackage : paralelo_serial_pkg

`default_nettype wire

// File: rtl/paralelo_serial_if.sv
//==============================================================================
// Module      : paralelo_serial_if
// Description : Byte handshake and serial output bundle of paralelo_serial.
//               With PARALELO_SERIAL_IDLE_CNT_EN defined the bundle also
//               carries the idle byte counter.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

interface paralelo_serial_if;

   logic [7:0] data_in;
   logic       valid_in;
   logic       ready_out;
   logic       data_out;
   logic       active;
`ifdef PARALELO_SERIAL_IDLE_CNT_EN
   logic [7:0] idle_count;

   // Byte source side
   modport master (
      output data_in,
      output valid_in,
      input  ready_out,
      input  data_out,
      input  active,
      input  idle_count
   );

   // Transmitter side
   modport slave (
      input  data_in,
      input  valid_in,
      output ready_out,
      output data_out,
      output active,
      output idle_count
   );
`else
   // Byte source side
   modport master (
      output data_in,
      output valid_in,
      input  ready_out,
      input  data_out,
      input  active
   );

   // Transmitter side
   modport slave (
      input  data_in,
      input  valid_in,
      output ready_out,
      output data_out,
      output active
   );
`endif

endinterface : paralelo_serial_if

`default_nettype wire

// File: rtl/paralelo_serial_shift_reg.sv
//==============================================================================
// Module      : ps_shift_reg
// Description : 8-bit load / shift-left register; the MSB is the serial
//               output. Loads take priority, every other edge shifts.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module ps_shift_reg (
   input  wire logic       clk,
   input  wire logic       rst,
   input  wire logic       i_load,
   input  wire logic [7:0] i_data,
   output logic            o_msb
);

   logic [7:0] r_sr;

   // Load a new byte at a boundary, otherwise shift one bit towards the MSB
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sr <= 8'h00;
      end else if (i_load) begin
         r_sr <= i_data;
      end else begin
         r_sr <= {r_sr[6:0], 1'b0};
      end
   end

   assign o_msb = r_sr[7];

endmodule : ps_shift_reg

`default_nettype wire

// File: rtl/paralelo_serial.sv
//==============================================================================
// Module      : paralelo_serial
// Description : Parallel-to-serial transmitter. After reset sends SYNC_COMMAS
//               comma bytes (0xBC), then accepts payload bytes through a
//               one-deep hold register and serialises them MSB first. Slots
//               with no payload carry a comma.
//               Optional macro PARALELO_SERIAL_IDLE_CNT_EN adds a saturating
//               count of comma bytes sent while running.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module paralelo_serial
   import paralelo_serial_pkg::*;
#(
   parameter int SYNC_COMMAS = 4   // legal range 1..7
) (
   input  wire logic        clk_32f,
   input  wire logic        reset,
   paralelo_serial_if.slave bus
);

   localparam logic [BIT_CNT_W-1:0] c_last_comma = BIT_CNT_W'(SYNC_COMMAS - 1);

   state_t                 r_state;
   state_t                 w_state_nxt;
   logic [BIT_CNT_W-1:0]   r_bit_cnt;
   logic [BIT_CNT_W-1:0]   r_comma_cnt;
   logic [7:0]             r_hold;
   logic                   r_hold_valid;

   logic                   w_boundary;
   logic                   w_ready;
   logic                   w_accept;
   logic                   w_load_data;
   logic [7:0]             w_load_byte;
   logic                   w_msb;

   assign w_boundary  = (r_bit_cnt == c_bit_last);
   assign w_ready     = (r_state == RUN) && !r_hold_valid;
   assign w_accept    = bus.valid_in && w_ready;
   // Only a byte held before this edge may be loaded; one accepted on the
   // boundary edge itself waits for the next slot.
   assign w_load_data = w_boundary && (r_state == RUN) && r_hold_valid;
   assign w_load_byte = w_load_data ? r_hold : COMMA;

   // State register
   always_ff @(posedge clk_32f or posedge reset) begin
      if (reset) begin
         r_state <= SYNC;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state: leave SYNC on the boundary that loads the last sync comma
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         SYNC: begin
            if (w_boundary && (r_comma_cnt == c_last_comma)) begin
               w_state_nxt = RUN;
            end
         end
         RUN: begin
            w_state_nxt = RUN;
         end
         default: begin
            w_state_nxt = SYNC;
         end
      endcase
   end

   // Bit position within the current byte; wraps 7 -> 0
   always_ff @(posedge clk_32f or posedge reset) begin
      if (reset) begin
         r_bit_cnt <= c_bit_last;
      end else begin
         r_bit_cnt <= r_bit_cnt + BIT_CNT_W'(1);
      end
   end

   // Count the sync commas loaded so far
   always_ff @(posedge clk_32f or posedge reset) begin
      if (reset) begin
         r_comma_cnt <= '0;
      end else if (w_boundary && (r_state == SYNC)) begin
         r_comma_cnt <= r_comma_cnt + BIT_CNT_W'(1);
      end
   end

   // One-deep hold register: capture on handshake, release on load
   always_ff @(posedge clk_32f or posedge reset) begin
      if (reset) begin
         r_hold       <= 8'h00;
         r_hold_valid <= 1'b0;
      end else if (w_accept) begin
         r_hold       <= bus.data_in;
         r_hold_valid <= 1'b1;
      end else if (w_load_data) begin
         r_hold_valid <= 1'b0;
      end
   end

`ifdef PARALELO_SERIAL_IDLE_CNT_EN
   logic [7:0] r_idle_cnt;

   // Saturating count of comma bytes sent while running
   always_ff @(posedge clk_32f or posedge reset) begin
      if (reset) begin
         r_idle_cnt <= 8'h00;
      end else if (w_boundary && (r_state == RUN) && !r_hold_valid
                   && (r_idle_cnt != 8'hFF)) begin
         r_idle_cnt <= r_idle_cnt + 8'd1;
      end
   end

   assign bus.idle_count = r_idle_cnt;
`endif

   ps_shift_reg u_shift_reg (
      .clk    (clk_32f),
      .rst    (reset),
      .i_load (w_boundary),
      .i_data (w_load_byte),
      .o_msb  (w_msb)
   );

   assign bus.data_out  = w_msb;
   assign bus.active    = (r_state == RUN);
   assign bus.ready_out = w_ready;

endmodule : paralelo_serial

`default_nettype wire

// File: tb/tb_paralelo_serial.sv
//==============================================================================
// Module      : tb_paralelo_serial
// Description : Self-checking bench for paralelo_serial. A slot-level model
//               (byte slots of eight edges, payload queue) predicts the serial
//               bit, active and ready_out after every rising edge.
//               Define PARALELO_SERIAL_IDLE_CNT_EN to also check idle_count.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_paralelo_serial;

   localparam int SYNC_COMMAS = 4;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_fail;

   paralelo_serial_if bus_if ();

   paralelo_serial #(.SYNC_COMMAS(SYNC_COMMAS)) dut (
      .clk_32f (clk),
      .reset   (reset),
      .bus     (bus_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model (slot level) ----------------
   int         m_edge;       // rising edges since reset release
   logic [7:0] m_pend[$];    // accepted bytes not yet placed in a slot
   logic [7:0] m_cur;        // byte occupying the current slot
   logic       m_bit;
   logic       m_active;
   logic       m_ready;
   logic       m_last_acc;
   int         m_idle;

   task automatic model_reset();
      m_edge     = 0;
      m_pend.delete();
      m_cur      = 8'h00;
      m_bit      = 1'b0;
      m_active   = 1'b0;
      m_ready    = 1'b0;
      m_last_acc = 1'b0;
      m_idle     = 0;
   endtask

   task automatic model_edge(input logic v, input logic [7:0] d);
      int pos;
      int slot;
      logic acc;
      m_edge++;
      pos  = (m_edge - 1) % 8;
      slot = (m_edge - 1) / 8;
      acc  = v && m_ready;
      if (pos == 0) begin
         if (slot >= SYNC_COMMAS && m_pend.size() > 0) begin
            m_cur = m_pend.pop_front();
         end else begin
            m_cur = 8'hBC;
            if (slot >= SYNC_COMMAS && m_idle < 255) m_idle++;
         end
      end
      if (acc) m_pend.push_back(d);
      m_active   = (slot >= SYNC_COMMAS - 1);
      m_ready    = m_active && (m_pend.size() == 0);
      m_bit      = m_cur[7 - pos];
      m_last_acc = acc;
   endtask

   // Drive inputs, take one rising edge, advance the model, park on negedge
   task automatic step(input logic v, input logic [7:0] d);
      bus_if.valid_in = v;
      bus_if.data_in  = d;
      @(posedge clk);
      model_edge(v, d);
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      bus_if.valid_in = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      model_reset();
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      @(negedge clk);
      reset = 1'b1;
      #1;
      n_checks++;
      if ({bus_if.data_out, bus_if.active, bus_if.ready_out} !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_outputs: dout/act/rdy got %b required 000",
                  {bus_if.data_out, bus_if.active, bus_if.ready_out});
      end
      do_reset();
      n_checks++;
      if ({bus_if.data_out, bus_if.active, bus_if.ready_out} !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_release: dout/act/rdy got %b required 000",
                  {bus_if.data_out, bus_if.active, bus_if.ready_out});
      end
   endtask

   task automatic test_sync();
      logic [31:0] exp_stream;
      logic [31:0] got_stream;
      int          act_edge;
      exp_stream = {4{8'hBC}};
      act_edge   = 0;
      for (int i = 0; i < 34; i++) begin
         step(1'b0, 8'h00);
         if (i < 32) got_stream[31 - i] = bus_if.data_out;
         if (act_edge == 0 && bus_if.active === 1'b1) act_edge = i + 1;
         n_checks++;
         if ({bus_if.data_out, bus_if.active, bus_if.ready_out} !==
             {m_bit, m_active, m_ready}) begin
            n_fail++;
            $display("FAIL sync edge %0d: dout/act/rdy got %b required %b", i + 1,
                     {bus_if.data_out, bus_if.active, bus_if.ready_out},
                     {m_bit, m_active, m_ready});
         end
      end
      n_checks++;
      if (got_stream !== exp_stream) begin
         n_fail++;
         $display("FAIL sync_stream: got %h required %h", got_stream, exp_stream);
      end
      n_checks++;
      if (act_edge != 25) begin
         n_fail++;
         $display("FAIL sync_active_edge: got %0d required 25", act_edge);
      end
   endtask

   task automatic test_single_byte();
      logic [7:0] got;
      int guard;
      guard = 0;
      while (!(m_ready && (m_edge % 8 == 3)) && guard < 40) begin
         step(1'b0, 8'h00);
         guard++;
      end
      step(1'b1, 8'hA5);
      n_checks++;
      if (!m_last_acc || guard >= 40) begin
         n_fail++;
         $display("FAIL single_accept: accepted %0b required 1", m_last_acc);
      end
      bus_if.valid_in = 1'b0;
      // run to the boundary that loads the byte, capture the 8 bits
      while (m_edge % 8 != 0) step(1'b0, 8'h00);
      got = 8'h00;
      for (int i = 0; i < 16; i++) begin
         step(1'b0, 8'h00);
         if (i < 8) got[7 - i] = bus_if.data_out;
         n_checks++;
         if ({bus_if.data_out, bus_if.active, bus_if.ready_out} !==
             {m_bit, m_active, m_ready}) begin
            n_fail++;
            $display("FAIL single edge %0d: dout/act/rdy got %b required %b", m_edge,
                     {bus_if.data_out, bus_if.active, bus_if.ready_out},
                     {m_bit, m_active, m_ready});
         end
      end
      n_checks++;
      if (got !== 8'hA5) begin
         n_fail++;
         $display("FAIL single_byte: got %h required a5", got);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] q[$];
      int guard;
      q = '{8'h01, 8'h02, 8'h03};
      guard = 0;
      while ((q.size() > 0 || m_pend.size() > 0 || m_edge % 8 != 0) && guard < 100) begin
         if (q.size() > 0) step(1'b1, q[0]);
         else              step(1'b0, 8'h00);
         if (m_last_acc) void'(q.pop_front());
         guard++;
         n_checks++;
         if ({bus_if.data_out, bus_if.active, bus_if.ready_out} !==
             {m_bit, m_active, m_ready}) begin
            n_fail++;
            $display("FAIL b2b edge %0d: dout/act/rdy got %b required %b", m_edge,
                     {bus_if.data_out, bus_if.active, bus_if.ready_out},
                     {m_bit, m_active, m_ready});
         end
      end
      n_checks++;
      if (guard >= 100) begin
         n_fail++;
         $display("FAIL b2b_timeout: %0d bytes left required 0", q.size());
      end
      for (int i = 0; i < 16; i++) begin
         step(1'b0, 8'h00);
         n_checks++;
         if ({bus_if.data_out, bus_if.active, bus_if.ready_out} !==
             {m_bit, m_active, m_ready}) begin
            n_fail++;
            $display("FAIL b2b_tail edge %0d: dout/act/rdy got %b required %b", m_edge,
                     {bus_if.data_out, bus_if.active, bus_if.ready_out},
                     {m_bit, m_active, m_ready});
         end
      end
   endtask

   task automatic test_boundary_accept();
      int guard;
      guard = 0;
      while (!(m_ready && (m_edge % 8 == 0)) && guard < 40) begin
         step(1'b0, 8'h00);
         guard++;
      end
      step(1'b1, 8'h3C);
      n_checks++;
      if (!m_last_acc || m_cur !== 8'hBC) begin
         n_fail++;
         $display("FAIL boundary_accept: accepted %0b slot %h required 1 bc",
                  m_last_acc, m_cur);
      end
      for (int i = 0; i < 23; i++) begin
         step(1'b0, 8'h00);
         n_checks++;
         if ({bus_if.data_out, bus_if.active, bus_if.ready_out} !==
             {m_bit, m_active, m_ready}) begin
            n_fail++;
            $display("FAIL boundary edge %0d: dout/act/rdy got %b required %b", m_edge,
                     {bus_if.data_out, bus_if.active, bus_if.ready_out},
                     {m_bit, m_active, m_ready});
         end
      end
   endtask

   task automatic test_random();
      logic       v;
      logic [7:0] d;
      for (int i = 0; i < 400; i++) begin
         v = 1'($urandom_range(0, 1));
         d = 8'($urandom);
         step(v, d);
         n_checks++;
         if ({bus_if.data_out, bus_if.active, bus_if.ready_out} !==
             {m_bit, m_active, m_ready}) begin
            n_fail++;
            $display("FAIL random edge %0d: dout/act/rdy got %b required %b", m_edge,
                     {bus_if.data_out, bus_if.active, bus_if.ready_out},
                     {m_bit, m_active, m_ready});
         end
      end
      bus_if.valid_in = 1'b0;
   endtask

   task automatic test_reset_mid();
      int guard;
      guard = 0;
      while (!m_ready && guard < 40) begin
         step(1'b0, 8'h00);
         guard++;
      end
      step(1'b1, 8'hA5);
      while ((m_pend.size() > 0 || m_edge % 8 != 3) && guard < 80) begin
         step(1'b0, 8'h00);
         guard++;
      end
      // now three bits into 0xA5; drop reset asynchronously mid-cycle
      reset = 1'b1;
      #1;
      n_checks++;
      if ({bus_if.data_out, bus_if.active, bus_if.ready_out} !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_mid_outputs: dout/act/rdy got %b required 000",
                  {bus_if.data_out, bus_if.active, bus_if.ready_out});
      end
      repeat (2) @(negedge clk);
      reset = 1'b0;
      model_reset();
      for (int i = 0; i < 48; i++) begin
         step(1'b0, 8'h00);
         n_checks++;
         if ({bus_if.data_out, bus_if.active, bus_if.ready_out} !==
             {m_bit, m_active, m_ready}) begin
            n_fail++;
            $display("FAIL reset_mid edge %0d: dout/act/rdy got %b required %b", m_edge,
                     {bus_if.data_out, bus_if.active, bus_if.ready_out},
                     {m_bit, m_active, m_ready});
         end
      end
   endtask

`ifdef PARALELO_SERIAL_IDLE_CNT_EN
   task automatic test_idle_count();
      do_reset();
      for (int i = 0; i < (SYNC_COMMAS + 300) * 8; i++) begin
         step(1'b0, 8'h00);
         if (m_edge % 8 == 1) begin
            n_checks++;
            if (bus_if.idle_count !== 8'(m_idle)) begin
               n_fail++;
               $display("FAIL idle_count edge %0d: got %0d required %0d", m_edge,
                        bus_if.idle_count, m_idle);
            end
         end
      end
      n_checks++;
      if (bus_if.idle_count !== 8'd255) begin
         n_fail++;
         $display("FAIL idle_count_sat: got %0d required 255", bus_if.idle_count);
      end
   endtask
`endif

   initial begin
      n_checks        = 0;
      n_fail          = 0;
      reset           = 1'b1;
      bus_if.valid_in = 1'b0;
      bus_if.data_in  = 8'h00;
      model_reset();
      test_reset();
      test_sync();
      test_single_byte();
      test_back_to_back();
      test_boundary_accept();
      test_random();
      test_reset_mid();
`ifdef PARALELO_SERIAL_IDLE_CNT_EN
      test_idle_count();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Run-time bound
   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, checks %0d", n_checks);
      $fatal(1, "watchdog expired");
   end

endmodule : tb_paralelo_serial

`default_nettype wire
